dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer sharing one single-port synchronous data memory
// between a CPU load/store port (m0) and a DMA/IO port (m1); one transaction in flight.
module dmem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MEM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_done,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_err,

  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_done,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_err,

  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_input,
  output logic                  mem_write_enable,
  input  logic [DATA_WIDTH-1:0] mem_data_output
);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StRdata
  } state_e;

  // One extra bit so a depth equal to 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0] MemDepthW = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  state_e                state_q, state_d;
  logic                  ptr_q, ptr_d;
  logic                  sel_q, sel_d;
  logic                  we_q, we_d;
  logic                  err_q, err_d;

  logic                  m0_gnt_q, m0_gnt_d;
  logic                  m1_gnt_q, m1_gnt_d;
  logic                  m0_done_q, m0_done_d;
  logic                  m1_done_q, m1_done_d;
  logic                  m0_err_q, m0_err_d;
  logic                  m1_err_q, m1_err_d;
  logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_WIDTH-1:0] m1_rdata_q, m1_rdata_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  mem_we_q, mem_we_d;

  logic                  win_valid;
  logic                  win_sel;
  logic                  win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;
  logic                  win_oor;

  // Pointer only breaks ties; a lone requester always wins.
  always_comb begin
    win_valid = 1'b0;
    win_sel   = 1'b0;
    if (m0_req && m1_req) begin
      win_valid = 1'b1;
      win_sel   = ptr_q;
    end else if (m0_req) begin
      win_valid = 1'b1;
      win_sel   = 1'b0;
    end else if (m1_req) begin
      win_valid = 1'b1;
      win_sel   = 1'b1;
    end
  end

  assign win_we    = win_sel ? m1_we    : m0_we;
  assign win_addr  = win_sel ? m1_addr  : m0_addr;
  assign win_wdata = win_sel ? m1_wdata : m0_wdata;
  assign win_oor   = ({1'b0, win_addr} >= MemDepthW);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    we_d        = we_q;
    err_d       = err_q;
    m0_gnt_d    = 1'b0;
    m1_gnt_d    = 1'b0;
    m0_done_d   = 1'b0;
    m1_done_d   = 1'b0;
    m0_err_d    = 1'b0;
    m1_err_d    = 1'b0;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (win_valid) begin
          sel_d       = win_sel;
          we_d        = win_we;
          err_d       = win_oor;
          // Memory port is loaded now so it is valid throughout the ISSUE cycle.
          mem_addr_d  = win_addr;
          mem_wdata_d = win_wdata;
          mem_we_d    = win_we & ~win_oor;
          m0_gnt_d    = ~win_sel;
          m1_gnt_d    = win_sel;
          ptr_d       = ~win_sel;
          state_d     = StIssue;
        end
      end

      StIssue: begin
        if (we_q || err_q) begin
          if (sel_q) begin
            m1_done_d = 1'b1;
            m1_err_d  = err_q;
            if (err_q) m1_rdata_d = '0;
          end else begin
            m0_done_d = 1'b1;
            m0_err_d  = err_q;
            if (err_q) m0_rdata_d = '0;
          end
          state_d = StIdle;
        end else begin
          state_d = StRdata;
        end
      end

      StRdata: begin
        if (sel_q) begin
          m1_done_d  = 1'b1;
          m1_rdata_d = mem_data_output;
        end else begin
          m0_done_d  = 1'b1;
          m0_rdata_d = mem_data_output;
        end
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= 1'b0;
      sel_q       <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      m0_gnt_q    <= 1'b0;
      m1_gnt_q    <= 1'b0;
      m0_done_q   <= 1'b0;
      m1_done_q   <= 1'b0;
      m0_err_q    <= 1'b0;
      m1_err_q    <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      err_q       <= err_d;
      m0_gnt_q    <= m0_gnt_d;
      m1_gnt_q    <= m1_gnt_d;
      m0_done_q   <= m0_done_d;
      m1_done_q   <= m1_done_d;
      m0_err_q    <= m0_err_d;
      m1_err_q    <= m1_err_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
    end
  end

  assign m0_gnt           = m0_gnt_q;
  assign m1_gnt           = m1_gnt_q;
  assign m0_done          = m0_done_q;
  assign m1_done          = m1_done_q;
  assign m0_err           = m0_err_q;
  assign m1_err           = m1_err_q;
  assign m0_rdata         = m0_rdata_q;
  assign m1_rdata         = m1_rdata_q;
  assign mem_address      = mem_addr_q;
  assign mem_data_input   = mem_wdata_q;
  assign mem_write_enable = mem_we_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 256 x 16 registered-read memory model attached.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [15:0] m0_addr = '0, m0_wdata = '0;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [15:0] m1_addr = '0, m1_wdata = '0;
  logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
  logic [15:0] m0_rdata, m1_rdata;
  logic [15:0] mem_address, mem_data_input, mem_data_output;
  logic        mem_write_enable;

  int tests = 0;
  int failed = 0;

  logic [15:0] mem [256];
  logic [15:0] mem_q;

  always #5 clk = ~clk;

  // Single-port memory: write cycles produce no read.
  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_address[7:0]] <= mem_data_input;
    else mem_q <= mem[mem_address[7:0]];
  end
  assign mem_data_output = mem_q;

  dmem_arbiter dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .m0_req           (m0_req),
    .m0_we            (m0_we),
    .m0_addr          (m0_addr),
    .m0_wdata         (m0_wdata),
    .m0_gnt           (m0_gnt),
    .m0_done          (m0_done),
    .m0_rdata         (m0_rdata),
    .m0_err           (m0_err),
    .m1_req           (m1_req),
    .m1_we            (m1_we),
    .m1_addr          (m1_addr),
    .m1_wdata         (m1_wdata),
    .m1_gnt           (m1_gnt),
    .m1_done          (m1_done),
    .m1_rdata         (m1_rdata),
    .m1_err           (m1_err),
    .mem_address      (mem_address),
    .mem_data_input   (mem_data_input),
    .mem_write_enable (mem_write_enable),
    .mem_data_output  (mem_data_output)
  );

  task automatic drive(input bit port, input bit req, input bit we, input logic [15:0] addr,
                       input logic [15:0] wdata);
    if (port) begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end
  endtask

  // Full transaction with bounded waits; returns on the negedge inside the done cycle.
  task automatic xact(input bit port, input bit we, input logic [15:0] addr,
                      input logic [15:0] wdata, output logic [15:0] rdata, output logic err);
    bit seen;
    rdata = 'x;
    err   = 1'bx;
    @(negedge clk);
    drive(port, 1'b1, we, addr, wdata);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (port ? m1_gnt : m0_gnt) seen = 1'b1;
    end
    drive(port, 1'b0, 1'b0, 16'h0, 16'h0);
    tests++;
    if (!seen) begin
      failed++;
      $display("FAIL xact_gnt port=%0d addr=%h: got no gnt, required gnt within 8 cycles",
               port, addr);
    end
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (port ? m1_done : m0_done) begin
        seen  = 1'b1;
        rdata = port ? m1_rdata : m0_rdata;
        err   = port ? m1_err : m0_err;
      end
    end
    tests++;
    if (!seen) begin
      failed++;
      $display("FAIL xact_done port=%0d addr=%h: got no done, required done within 8 cycles",
               port, addr);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests++;
    if ({m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, mem_write_enable} !== 7'b0) begin
      failed++;
      $display("FAIL reset_flags: got %b, required 0000000",
               {m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, mem_write_enable});
    end
    tests++;
    if ({m0_rdata, m1_rdata, mem_address, mem_data_input} !== 64'h0) begin
      failed++;
      $display("FAIL reset_data: got %h, required 0",
               {m0_rdata, m1_rdata, mem_address, mem_data_input});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write();
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 16'h0005, 16'hBEEF);
    @(negedge clk);
    tests++;
    if ({m0_gnt, m1_gnt, m0_done, mem_write_enable} !== 4'b1001) begin
      failed++;
      $display("FAIL wr_gnt_cycle: gnt0,gnt1,done0,we=%b required 1001",
               {m0_gnt, m1_gnt, m0_done, mem_write_enable});
    end
    tests++;
    if (mem_address !== 16'h0005 || mem_data_input !== 16'hBEEF) begin
      failed++;
      $display("FAIL wr_mem_bus: addr=%h data=%h required 0005 BEEF", mem_address,
               mem_data_input);
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    tests++;
    if ({m0_gnt, m0_done, m0_err, mem_write_enable, m1_done} !== 5'b01000) begin
      failed++;
      $display("FAIL wr_done_cycle: gnt0,done0,err0,we,done1=%b required 01000",
               {m0_gnt, m0_done, m0_err, mem_write_enable, m1_done});
    end
    @(negedge clk);
    tests++;
    if ({m0_done, mem_write_enable} !== 2'b00) begin
      failed++;
      $display("FAIL wr_after: done0,we=%b required 00", {m0_done, mem_write_enable});
    end
  endtask

  task automatic test_read();
    drive(1'b1, 1'b1, 1'b0, 16'h0005, 16'h0);
    @(negedge clk);
    tests++;
    if ({m1_gnt, m0_gnt, mem_write_enable} !== 3'b100 || mem_address !== 16'h0005) begin
      failed++;
      $display("FAIL rd_gnt_cycle: gnt1,gnt0,we=%b addr=%h required 100 0005",
               {m1_gnt, m0_gnt, mem_write_enable}, mem_address);
    end
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    tests++;
    if ({m1_done, mem_write_enable} !== 2'b00) begin
      failed++;
      $display("FAIL rd_wait_cycle: done1,we=%b required 00", {m1_done, mem_write_enable});
    end
    @(negedge clk);
    tests++;
    if ({m1_done, m1_err, m0_done, mem_write_enable} !== 4'b1000 || m1_rdata !== 16'hBEEF) begin
      failed++;
      $display("FAIL rd_done_cycle: done1,err1,done0,we=%b rdata=%h required 1000 BEEF",
               {m1_done, m1_err, m0_done, mem_write_enable}, m1_rdata);
    end
    @(negedge clk);
    tests++;
    if (m1_done !== 1'b0 || m1_rdata !== 16'hBEEF) begin
      failed++;
      $display("FAIL rd_hold: done1=%b rdata=%h required 0 BEEF", m1_done, m1_rdata);
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] rd;
    logic        er;
    logic [1:0]  exp_gnt, exp_done;
    xact(1'b0, 1'b1, 16'h0001, 16'h1111, rd, er);
    xact(1'b1, 1'b1, 16'h0002, 16'h2222, rd, er);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 16'h0001, 16'h0);
    drive(1'b1, 1'b1, 1'b0, 16'h0002, 16'h0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp_gnt  = 2'b00;
      exp_done = 2'b00;
      if (k % 3 == 1) exp_gnt = (((k - 1) / 3) % 2 == 0) ? 2'b01 : 2'b10;
      if (k % 3 == 0) exp_done = (((k / 3) - 1) % 2 == 0) ? 2'b01 : 2'b10;
      tests++;
      if ({m1_gnt, m0_gnt} !== exp_gnt || {m1_done, m0_done} !== exp_done) begin
        failed++;
        $display("FAIL rr_cycle%0d: gnt(1,0)=%b done(1,0)=%b required %b %b", k,
                 {m1_gnt, m0_gnt}, {m1_done, m0_done}, exp_gnt, exp_done);
      end
      if (exp_done == 2'b01) begin
        tests++;
        if (m0_rdata !== 16'h1111) begin
          failed++;
          $display("FAIL rr_data0_cycle%0d: rdata=%h required 1111", k, m0_rdata);
        end
      end
      if (exp_done == 2'b10) begin
        tests++;
        if (m1_rdata !== 16'h2222) begin
          failed++;
          $display("FAIL rr_data1_cycle%0d: rdata=%h required 2222", k, m1_rdata);
        end
      end
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_range_err();
    logic [15:0] rd;
    logic        er;
    xact(1'b1, 1'b1, 16'h0000, 16'hA5A5, rd, er);
    xact(1'b1, 1'b1, 16'h00FF, 16'h0FF0, rd, er);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 16'h0100, 16'h1234);
    @(negedge clk);
    tests++;
    if ({m0_gnt, mem_write_enable} !== 2'b10) begin
      failed++;
      $display("FAIL err_issue: gnt0,we=%b required 10", {m0_gnt, mem_write_enable});
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    tests++;
    if ({m0_done, m0_err, mem_write_enable} !== 3'b110 || m0_rdata !== 16'h0000) begin
      failed++;
      $display("FAIL err_done: done0,err0,we=%b rdata=%h required 110 0000",
               {m0_done, m0_err, mem_write_enable}, m0_rdata);
    end
    xact(1'b0, 1'b0, 16'h0000, 16'h0, rd, er);
    tests++;
    if (rd !== 16'hA5A5 || er !== 1'b0) begin
      failed++;
      $display("FAIL err_addr0_intact: rdata=%h err=%b required A5A5 0", rd, er);
    end
    xact(1'b0, 1'b0, 16'h00FF, 16'h0, rd, er);
    tests++;
    if (rd !== 16'h0FF0 || er !== 1'b0) begin
      failed++;
      $display("FAIL err_last_in_range: rdata=%h err=%b required 0FF0 0", rd, er);
    end
    xact(1'b1, 1'b0, 16'hFFFF, 16'h0, rd, er);
    tests++;
    if (er !== 1'b1 || rd !== 16'h0000) begin
      failed++;
      $display("FAIL err_ffff: rdata=%h err=%b required 0000 1", rd, er);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] rd;
    logic        er;
    xact(1'b0, 1'b1, 16'h0010, 16'h0101, rd, er);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 16'h0010, 16'h7777);
    @(negedge clk);
    tests++;
    if ({m1_gnt, mem_write_enable} !== 2'b11) begin
      failed++;
      $display("FAIL mid_issue: gnt1,we=%b required 11", {m1_gnt, mem_write_enable});
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({mem_write_enable, m1_gnt, m1_done} !== 3'b000) begin
      failed++;
      $display("FAIL mid_reset_async: we,gnt1,done1=%b required 000",
               {mem_write_enable, m1_gnt, m1_done});
    end
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (m1_done !== 1'b0 || mem_write_enable !== 1'b0) begin
        failed++;
        $display("FAIL mid_no_done%0d: done1=%b we=%b required 0 0", k, m1_done,
                 mem_write_enable);
      end
    end
    drive(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
    drive(1'b1, 1'b1, 1'b0, 16'h0002, 16'h0);
    @(negedge clk);
    tests++;
    if ({m1_gnt, m0_gnt} !== 2'b01) begin
      failed++;
      $display("FAIL mid_ptr: gnt(1,0)=%b required 01", {m1_gnt, m0_gnt});
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (m0_done !== 1'b1 || m0_rdata !== 16'h0101) begin
      failed++;
      $display("FAIL mid_not_written: done0=%b rdata=%h required 1 0101", m0_done, m0_rdata);
    end
    @(negedge clk);
    tests++;
    if (m1_gnt !== 1'b1) begin
      failed++;
      $display("FAIL mid_m1_next: gnt1=%b required 1", m1_gnt);
    end
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (m1_done !== 1'b1 || m1_rdata !== 16'h2222) begin
      failed++;
      $display("FAIL mid_m1_data: done1=%b rdata=%h required 1 2222", m1_done, m1_rdata);
    end
  endtask

  task automatic test_req_pulse();
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 16'h0033, 16'h5555);
    #2;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests++;
      if ({m0_gnt, m1_gnt, m0_done, m1_done, mem_write_enable} !== 5'b0 ||
          mem_address !== 16'h0002) begin
        failed++;
        $display("FAIL pulse_idle%0d: gnt/done/we=%b addr=%h required 00000 0002", k,
                 {m0_gnt, m1_gnt, m0_done, m1_done, mem_write_enable}, mem_address);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_range_err();
    test_reset_mid();
    test_req_pulse();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
